// File: rtl/fetch_sequencer.sv
// Fetch/issue controller for the 16-bit, 12-bit-PC processor.
// It owns the PC, fetches from instruction memory and presents each instruction
// to the execute stage. For branch-class instructions it strobes the branch
// resolver and applies the resolved next PC. It also handles halt, memory
// timeout and a retired-instruction counter.
//
// Handshake: instr_out is transferred on a cycle where instr_valid and exec_ready
// are both 1. Once instr_valid rises, instr_out stays stable and instr_valid
// stays high until that transfer cycle. exec_ready may change freely.
//
// imem_req is a registered output that is high during the single FETCH cycle
// that issues a request. Coming out of reset the register is still 0, so the
// first FETCH cycle only arms the request and the following cycle issues it.
// Every later entry into FETCH arms the request on the transition, which lets
// a zero-wait instruction take exactly FETCH, WAIT_MEM, ISSUE.
module fetch_sequencer #(
  parameter logic [7:0]  MEM_TIMEOUT = 8'd8,
  parameter logic [15:0] HALT_INSN   = 16'h0003,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  input  logic        exec_ready,
  output logic        en_branch,
  input  logic        branch_taken,
  input  logic [11:0] branch_target,
  input  logic        restart,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    WAIT_MEM = 3'd1,
    ISSUE    = 3'd2,
    RESOLVE  = 3'd3,
    HALT     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t      state, state_d;
  logic [11:0] pc, pc_d;
  logic [7:0]  cnt, cnt_d;
  logic [15:0] instr_d;
  logic [15:0] retired_d;
  logic        valid_d;
  logic        req_d;
  logic        en_d;
  logic        halted_d;
  logic        fault_d;

  assign imem_addr = pc;
  assign dbg_state = state;

  // State, PC, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      cnt         <= 8'd0;
      instr_out   <= 16'd0;
      instr_valid <= 1'b0;
      retired     <= 16'd0;
      imem_req    <= 1'b0;
      en_branch   <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      cnt         <= cnt_d;
      instr_out   <= instr_d;
      instr_valid <= valid_d;
      retired     <= retired_d;
      imem_req    <= req_d;
      en_branch   <= en_d;
      halted      <= halted_d;
      fault       <= fault_d;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    cnt_d     = cnt;
    instr_d   = instr_out;
    valid_d   = instr_valid;
    retired_d = retired;
    req_d     = 1'b0;
    en_d      = 1'b0;
    case (state)
      FETCH: begin
        cnt_d = 8'd0;
        if (imem_req) begin
          state_d = WAIT_MEM;
        end else begin
          req_d = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (imem_valid) begin
          // A response on the final count still wins over the timeout.
          instr_d = imem_rdata;
          if (imem_rdata == HALT_INSN) begin
            state_d = HALT;
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 8'd1;
          if (cnt_d == MEM_TIMEOUT) begin
            state_d = FAULT;
          end
        end
      end
      ISSUE: begin
        if (exec_ready) begin
          valid_d = 1'b0;
          if (retired != 16'hFFFF) begin
            retired_d = retired + 16'd1;
          end
          if (instr_out[1:0] == 2'd2) begin
            state_d = RESOLVE;
            en_d    = 1'b1;
          end else begin
            pc_d    = pc + 12'd1;
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end
      end
      RESOLVE: begin
        // instr_out is untouched here so the resolver still sees the branch.
        pc_d    = branch_taken ? branch_target : (pc + 12'd1);
        state_d = FETCH;
        req_d   = 1'b1;
      end
      HALT, FAULT: begin
        if (restart) begin
          pc_d    = RESET_PC;
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    halted_d = (state_d == HALT);
    fault_d  = (state_d == FAULT);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a memory model with programmable
// latency, a monitor that checks every fetch address and every accepted
// instruction against expected queues, a table of branch vectors and hand
// sequences for stall, halt/restart, timeout, PC wrap and mid-operation reset.
module tb_fetch_sequencer;

  localparam logic [15:0] HALT_INSN = 16'h0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        exec_ready;
  logic        en_branch;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        restart;
  logic        halted;
  logic        fault;
  logic [15:0] retired;
  logic [2:0]  dbg_state;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .exec_ready(exec_ready),
    .en_branch(en_branch), .branch_taken(branch_taken), .branch_target(branch_target),
    .restart(restart), .halted(halted), .fault(fault), .retired(retired),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state.
  logic [11:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];
  logic [15:0] exp_retired;
  logic [15:0] mem [4096];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          mem_lat = 1;

  typedef struct {
    logic [15:0] instr;
    logic        taken;
    logic [11:0] target;
    logic [11:0] exp_next;
    int          exp_en;
  } br_vec_t;

  br_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Expect a fetch at addr returning instr; non-halt instructions will retire.
  task automatic push_fetch(input logic [11:0] addr, input logic [15:0] instr);
    exp_addr_q.push_back(addr);
    mem[addr] = instr;
    if (instr != HALT_INSN) begin
      exp_instr_q.push_back(instr);
      exp_retired = exp_retired + 16'd1;
    end
  endtask

  task automatic restart_pulse();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(halted || fault) && n < 3000);
    if (n >= 3000) flag({name, "_idle_timeout"}, 32'(dbg_state));
    check({name, "_addr_q_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_instr_q_left"}, 32'(exp_instr_q.size()), 32'd0);
    check({name, "_retired"}, 32'(retired), 32'(exp_retired));
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 100);
    if (n >= 100) flag({name, "_req_timeout"}, 32'(dbg_state));
  endtask

  // Monitor and memory model: sample DUT outputs at negedge, then drive memory.
  initial begin
    int          pend;
    logic [11:0] req_addr;
    pend       = 0;
    req_addr   = 12'd0;
    imem_valid = 1'b0;
    imem_rdata = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend       = 0;
        imem_valid = 1'b0;
      end else begin
        if (imem_req) begin
          if (exp_addr_q.size() == 0) flag("unexpected_req", 32'(imem_addr));
          else check("fetch_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (instr_valid && exec_ready) begin
          if (exp_instr_q.size() == 0) flag("unexpected_issue", 32'(instr_out));
          else check("issued_instr", 32'(instr_out), 32'(exp_instr_q.pop_front()));
        end else if (instr_valid && exp_instr_q.size() == 0) begin
          flag("unexpected_valid", 32'(instr_out));
        end
        if (en_branch) begin
          en_cnt++;
          check("branch_instr_held", 32'(instr_out[1:0]), 32'd2);
        end
        imem_valid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[req_addr];
          end
        end
        if (imem_req && mem_lat > 0) begin
          req_addr = imem_addr;
          pend     = mem_lat;
        end
      end
    end
  end

  // Test sequence.
  initial begin
    int          en0;
    logic [15:0] r0;
    rst_n         = 1'b0;
    exec_ready    = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 12'd0;
    restart       = 1'b0;
    exp_retired   = 16'd0;
    for (int i = 0; i < 4096; i++) mem[i] = HALT_INSN;

    vecs[0] = '{instr: 16'h0802, taken: 1'b1, target: 12'h080, exp_next: 12'h080, exp_en: 1};
    vecs[1] = '{instr: 16'h0802, taken: 1'b0, target: 12'h080, exp_next: 12'h006, exp_en: 1};
    vecs[2] = '{instr: 16'h7F02, taken: 1'b1, target: 12'h7F0, exp_next: 12'h7F0, exp_en: 1};
    vecs[3] = '{instr: 16'h0801, taken: 1'b1, target: 12'h080, exp_next: 12'h006, exp_en: 0};

    // Reset values.
    #22;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'h000);
    check("rst_instr_out", 32'(instr_out), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_en_branch", 32'(en_branch), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // Linear run, 1-cycle latency, exec_ready=1.
    push_fetch(12'h000, 16'h0010);
    push_fetch(12'h001, 16'h0011);
    push_fetch(12'h002, 16'h0021);
    push_fetch(12'h003, HALT_INSN);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle("linear");
    check("linear_halted", 32'(halted), 32'd1);

    // Branch vector table: NOPs at 0..4, the vector instruction at 5.
    for (int v = 0; v < 4; v++) begin
      branch_taken  = vecs[v].taken;
      branch_target = vecs[v].target;
      for (int a = 0; a < 5; a++) push_fetch(12'(a), 16'h0000);
      push_fetch(12'h005, vecs[v].instr);
      push_fetch(vecs[v].exp_next, HALT_INSN);
      en0 = en_cnt;
      restart_pulse();
      wait_idle($sformatf("branch_vec%0d", v));
      check($sformatf("branch_vec%0d_en_pulses", v), 32'(en_cnt - en0), 32'(vecs[v].exp_en));
      for (int a = 0; a < 6; a++) mem[a] = HALT_INSN;
    end
    branch_taken = 1'b0;

    // Stall: exec_ready low for 4 ISSUE cycles.
    exec_ready = 1'b0;
    push_fetch(12'h000, 16'h0010);
    push_fetch(12'h001, HALT_INSN);
    r0 = retired;
    restart_pulse();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!instr_valid && n < 100);
      if (n >= 100) flag("stall_valid_timeout", 32'(dbg_state));
    end
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr_stable", 32'(instr_out), 32'h0010);
      check("stall_retired_held", 32'(retired), 32'(r0));
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1 exec_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_retired_inc", 32'(retired), 32'(r0 + 16'd1));
    wait_idle("stall");

    // PC wrap: branch at 0 taken to FFF, non-branch at FFF wraps to 0,
    // then the same branch not taken goes to 1.
    mem[12'hFFF]  = 16'h0010;
    branch_taken  = 1'b1;
    branch_target = 12'hFFF;
    push_fetch(12'h000, 16'h0002);
    push_fetch(12'hFFF, 16'h0010);
    push_fetch(12'h000, 16'h0002);
    push_fetch(12'h001, HALT_INSN);
    en0 = en_cnt;
    restart_pulse();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!en_branch && n < 100);
      if (n >= 100) flag("wrap_en_timeout", 32'(dbg_state));
    end
    @(posedge clk); #1 branch_taken = 1'b0;
    wait_idle("wrap");
    check("wrap_en_pulses", 32'(en_cnt - en0), 32'd2);
    mem[12'h000] = HALT_INSN;
    mem[12'hFFF] = HALT_INSN;

    // Halt then restart.
    push_fetch(12'h000, HALT_INSN);
    restart_pulse();
    wait_idle("halt");
    check("halt_halted", 32'(halted), 32'd1);
    repeat (5) @(negedge clk);
    check("halt_still_halted", 32'(halted), 32'd1);
    push_fetch(12'h000, HALT_INSN);
    restart_pulse();
    check("restart_halted_clear", 32'(halted), 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'h000);
    wait_idle("restart");

    // Timeout: no response at all.
    mem_lat = 0;
    exp_addr_q.push_back(12'h000);
    restart_pulse();
    wait_req("timeout");
    repeat (8) @(negedge clk);
    check("timeout_no_fault_yet", 32'(fault), 32'd0);
    @(negedge clk);
    check("timeout_fault", 32'(fault), 32'd1);

    // Response on the 8th WAIT_MEM cycle wins; restart out of FAULT.
    mem_lat = 8;
    push_fetch(12'h000, 16'h0010);
    push_fetch(12'h001, HALT_INSN);
    restart_pulse();
    check("fault_cleared", 32'(fault), 32'd0);
    wait_req("late");
    repeat (9) @(negedge clk);
    check("late_no_fault", 32'(fault), 32'd0);
    check("late_valid", 32'(instr_valid), 32'd1);
    wait_idle("late");
    check("late_halted", 32'(halted), 32'd1);

    // Reset in the middle of WAIT_MEM.
    mem_lat = 0;
    exp_addr_q.push_back(12'h000);
    restart_pulse();
    wait_req("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_imem_addr", 32'(imem_addr), 32'h000);
    check("midrst_instr_out", 32'(instr_out), 32'd0);
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_en_branch", 32'(en_branch), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    exp_retired = 16'd0;
    mem_lat     = 1;
    push_fetch(12'h000, 16'h0010);
    push_fetch(12'h001, HALT_INSN);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch/issue controller for the 16-bit, 12-bit-PC processor.
- Owns the PC and issues fetches to instruction memory, then presents each instruction to the execute stage with a valid/ready handshake.
- For branch-class instructions (instr[1:0]==2) it strobes en_branch into the combinational branch resolver and applies the resolved next PC.
- Also handles halt, memory timeout and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 8: max cycles spent in WAIT_MEM before a fault; counter is 8 bits wide, legal range 1..255.
- HALT_INSN, 16'h0003: instruction encoding that stops the sequencer.
- RESET_PC, 12'h000: PC loaded on reset and on restart.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  one-cycle fetch request
- imem_addr  out  12  fetch address, equals pc
- imem_valid  in  1  read data valid; may arrive 1..N cycles after imem_req
- imem_rdata  in  16  fetched instruction
- instr_out  out  16  instruction presented to execute stage
- instr_valid  out  1  instr_out valid
- exec_ready  in  1  execute stage accepts instr_out
- en_branch  out  1  one-cycle strobe to branch resolver
- branch_taken  in  1  resolver result, sampled in the cycle en_branch=1
- branch_target  in  12  resolver target, sampled with branch_taken
- restart  in  1  leaves HALT/FAULT, reloads RESET_PC
- halted  out  1  high in HALT
- fault  out  1  high in FAULT (memory timeout)
- retired  out  16  count of accepted instructions, saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously):
  - state=FETCH, pc=RESET_PC, timeout counter=0, retired=0.
  - imem_req=0, imem_addr=RESET_PC, instr_out=0, instr_valid=0, en_branch=0, halted=0, fault=0.
- All outputs are registered except imem_addr, which is driven directly from pc.
- FETCH:
  - imem_req=1 for exactly one cycle at imem_addr=pc.
  - Next state WAIT_MEM; timeout counter cleared.
- WAIT_MEM:
  - imem_req=0.
  - On imem_valid=1: instr_out<=imem_rdata.
    - If imem_rdata==HALT_INSN: next state HALT; instr_valid stays 0 and retired is not incremented.
    - Otherwise: next state ISSUE with instr_valid<=1.
  - Without imem_valid the counter increments. When it reaches MEM_TIMEOUT, next state FAULT.
  - imem_valid in the same cycle as the final count wins: the instruction is captured, no fault.
  - imem_valid outside WAIT_MEM is ignored.
- ISSUE:
  - instr_valid=1; instr_out is held stable until exec_ready=1.
  - On the handshake: instr_valid<=0 and retired increments, saturating.
    - If instr_out[1:0]==2: next state RESOLVE.
    - Otherwise: pc<=pc+1 (12-bit wrap, 12'hFFF -> 12'h000) and next state FETCH.
- RESOLVE:
  - en_branch=1 for one cycle; branch_taken and branch_target are sampled in that cycle.
  - Taken: pc<=branch_target. Not taken: pc<=pc+1, wrapping.
  - Next state FETCH.
  - instr_out is held through RESOLVE so the resolver still sees the branch instruction.
- HALT: halted=1; no fetches; the PC keeps the halt address.
- FAULT: fault=1; no fetches.
- restart:
  - In HALT or FAULT: pc<=RESET_PC, halted and fault cleared, retired kept, next state FETCH.
  - In any other state: ignored.
- Back-to-back: a non-branch instruction costs at least 3 cycles (FETCH, WAIT_MEM, ISSUE) with zero memory wait and exec_ready=1. A branch adds 1 cycle (RESOLVE).
- Reset mid-operation: immediate return to the reset values; any in-flight imem_valid after reset release is ignored, because the state is FETCH, not WAIT_MEM.

Test Plan:
- Linear run: memory returns 16'h0010,16'h0011,16'h0021 with 1-cycle latency and exec_ready=1 -> imem_addr sequence 0,1,2,3; retired=3; each instruction issued exactly once.
- Taken branch: instr at pc 5 = 16'h0802 (target 12'h080), branch_taken=1 -> en_branch pulses 1 cycle; next imem_addr=12'h080.
- Not-taken branch: same instruction with branch_taken=0 -> next imem_addr=6.
- Stall: exec_ready held low 4 cycles in ISSUE -> instr_valid=1 and instr_out stable all 4 cycles; retired increments only on the accepting cycle.
- Halt/restart: fetch returns 16'h0003 -> halted=1, instr_valid never 1, no further imem_req. Pulse restart -> halted=0, imem_req at addr 0.
- Timeout/wrap:
  - With imem_valid never asserted, fault=1 after 8 WAIT_MEM cycles.
  - With imem_valid on the 8th cycle, no fault.
  - A non-branch at pc 12'hFFF -> next fetch at 12'h000.
  - rst_n low mid-WAIT_MEM -> all outputs return to reset values immediately.
